// File: rtl/sw_pkg.sv
// Shared types and constants for the Smith-Waterman sequencing blocks.
package sw_pkg;
  localparam int SW_DATA_WIDTH = 8;
  localparam int SW_DEPTH      = 128;
  localparam int SW_LEN_W      = 8;

  localparam logic [7:0] BASE_A = 8'h41;
  localparam logic [7:0] BASE_C = 8'h43;
  localparam logic [7:0] BASE_G = 8'h47;
  localparam logic [7:0] BASE_T = 8'h54;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DONE
  } state_t;
endpackage

// File: rtl/seq_base_check.sv
// Combinational DNA base validator: ok is high only for 'A', 'C', 'G' or 'T'.
module seq_base_check
  import sw_pkg::*;
#(
  parameter int DATA_WIDTH = SW_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] base,
  output logic                  ok
);
  assign ok = (base == DATA_WIDTH'(BASE_A)) || (base == DATA_WIDTH'(BASE_C)) ||
              (base == DATA_WIDTH'(BASE_G)) || (base == DATA_WIDTH'(BASE_T));
endmodule

// File: rtl/seq_stream_ctrl.sv
// Loads a base sequence into the register file, then streams/replays it at one base per cycle with zero read
// latency; out_data/out_valid/out_last hold while out_ready=0. SEQ_STREAM_BASE_CHECK_EN enables base checking.
module seq_stream_ctrl
  import sw_pkg::*;
#(
  parameter int DATA_WIDTH = SW_DATA_WIDTH,
  parameter int DEPTH      = SW_DEPTH,
  parameter int LEN_W      = SW_LEN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  replay,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      seq_len,
  output logic                  err,
  output logic                  rf_w_en,
  output logic [31:0]           rf_w_addr,
  output logic [31:0]           rf_w_data,
  output logic [31:0]           rf_r_addr,
  input  logic [31:0]           rf_r_data
);
  state_t           st;
  logic [LEN_W-1:0] wr_ptr;
  logic [LEN_W-1:0] rd_ptr;
  logic             base_ok;
  logic             accept;
  logic             final_wr;
  logic             unused_rdata;

`ifdef SEQ_STREAM_BASE_CHECK_EN
  seq_base_check #(.DATA_WIDTH(DATA_WIDTH)) u_base_check (
    .base (in_data),
    .ok   (base_ok)
  );
`else
  assign base_ok = 1'b1;
`endif

  assign accept   = in_ready & in_valid;
  assign rf_w_en  = accept & base_ok;
  // The accept that fills the last entry ends LOAD even without in_last.
  assign final_wr = in_last | (seq_len == LEN_W'(DEPTH - 1));

  assign rf_w_addr = 32'(wr_ptr);
  assign rf_w_data = rf_w_en ? 32'(in_data) : 32'd0;
  assign rf_r_addr = 32'(rd_ptr);
  assign out_data  = out_valid ? rf_r_data[DATA_WIDTH-1:0] : '0;
  assign out_last  = out_valid & (rd_ptr == seq_len - 1'b1);

  assign unused_rdata = ^rf_r_data[31:DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      seq_len   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (load) begin
            st       <= ST_LOAD;
            wr_ptr   <= '0;
            seq_len  <= '0;
            err      <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end else if (replay && (seq_len != '0)) begin
            st        <= ST_STREAM;
            rd_ptr    <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (!base_ok) begin
              st       <= ST_IDLE;
              err      <= 1'b1;
              seq_len  <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b0;
            end else begin
              wr_ptr  <= wr_ptr + 1'b1;
              seq_len <= seq_len + 1'b1;
              if (final_wr) begin
                st        <= ST_STREAM;
                rd_ptr    <= '0;
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
              end
            end
          end
        end
        ST_STREAM: begin
          if (out_ready) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (out_last) begin
              st        <= ST_DONE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          st   <= ST_IDLE;
          done <= 1'b0;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end
endmodule
